temp_sample_writer: RTL
=======================

# temp_sample_writer

Upstream feeder for the sensor configuration/status register block. It accepts raw temperature samples over a valid/ready handshake and accumulates a power-of-two batch. It then issues a single-cycle register write of the truncated average to the sensor's register address. Its `write`/`address`/`wr_data` outputs connect directly to the register block's `write`/`address`/`data_in` inputs.

## Interface
- `DATA_W`, 16: sample and register data width.
- `SAMPLES_LOG2`, 2: log2 of batch size (N = 4 by default); legal 0..4.
- `SENSOR_ADDR`, 3'b010: register address written with each average.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  block enable; low discards any partial batch.
- `sample_valid`  in  1  upstream sample present.
- `sample_data`  in  DATA_W  unsigned raw sample.
- `sample_ready`  out  1  block can accept a sample this cycle.
- `write`  out  1  one-cycle register write strobe.
- `address`  out  3  register address; equals SENSOR_ADDR while `write`=1, else 3'b000.
- `wr_data`  out  DATA_W  averaged value; holds the last written average between writes.
- `wr_count`  out  8  number of completed writes, wraps 255→0.

## Operation
- Three-state FSM:
  - IDLE: `sample_ready`=0.
  - ACCUM: `sample_ready`=1.
  - WRITE: `sample_ready`=0, `write`=1.
- IDLE→ACCUM when `enable`=1.
- ACCUM→IDLE when `enable`=0. This clears the accumulator and the sample counter, and no write occurs.
- In ACCUM, a sample is accepted only on `sample_valid`&&`sample_ready`.
  - The accumulator adds `sample_data`.
  - The sample counter increments.
- When the Nth sample is accepted, the next state is WRITE.
- WRITE lasts exactly one cycle.
  - `wr_data` = (sum of N samples) >> SAMPLES_LOG2. The average is truncated, never rounded.
  - `wr_count` increments.
  - The accumulator and counter clear.
- WRITE→ACCUM if `enable`=1, else WRITE→IDLE. The write always completes even if `enable` drops during WRITE.
- Accumulator width is DATA_W+SAMPLES_LOG2. No overflow is possible, so the all-ones input averages to all-ones.
- `sample_valid` asserted during IDLE or WRITE is not accepted. Upstream must hold the sample until `sample_ready`.

## Timing
- Reset values: `sample_ready`=0, `write`=0, `address`=3'b000, `wr_data`=0, `wr_count`=0, FSM=IDLE, accumulator=0, sample counter=0.
- Reset asserted mid-batch or during WRITE takes effect immediately (asynchronously). A partial batch is lost and no write is emitted.
- `sample_ready` rises the cycle after `enable` is sampled high in IDLE.
- Latency: `write` is high in the cycle immediately after the edge that accepts the Nth sample.
- `wr_data` and `address` are valid in the same cycle as `write`. `wr_data` is registered and changes only on entry to WRITE.
- Minimum batch period is N+1 cycles: N accepts plus 1 WRITE cycle.
- SAMPLES_LOG2=0 gives N=1. Each accepted sample is written unchanged one cycle later.

## Structure
- Shared package `temp_sensor_pkg` holds:
  - the register address constants (including sensor 0 = 3'b010);
  - the FSM state enum (IDLE, ACCUM, WRITE);
  - the default DATA_W.
- The register block and this block both import `temp_sensor_pkg`.
- Optional single sub-module `sample_accumulator` (clear, add-enable, sum, count, batch_done). The FSM stays in `temp_sample_writer`.

## Test plan
- enable=1; samples 10, 20, 30, 40 on consecutive cycles → next cycle `write`=1 for one cycle, `address`=3'b010, `wr_data`=25, `wr_count`=1; with the register block attached, its `data_out`=25 afterwards.
- Samples 1, 1, 1, 2 → `wr_data`=1 (truncation). Four samples of 16'hFFFF → `wr_data`=16'hFFFF (no wrap).
- Accept 2 samples of 100, drop `enable` for one cycle, raise it, then send four samples of 8 → single write with `wr_data`=8, `wr_count`=1.
- Hold `sample_valid`=1 with value 7 continuously → accepts in 4 cycles, WRITE cycle with `sample_ready`=0 and no accept, then accepts resume; writes occur every 5 cycles with `wr_data`=7.
- Assert `reset` after 3 accepted samples (mid-cycle, between edges) → outputs go to reset values immediately, no `write` pulse. After release, a fresh 4-sample batch of 4 → `wr_data`=4.
- Run 256 batches → `wr_count` wraps to 0.

Source files
------------

// File: rtl/temp_sensor_pkg.sv
// rtl/temp_sensor_pkg.sv - shared constants and types for the temperature sensor register path
package temp_sensor_pkg;

    localparam int DATA_W_DEFAULT = 16;

    localparam logic [2:0] ADDR_IDLE    = 3'b000;
    localparam logic [2:0] ADDR_STATUS  = 3'b001;
    localparam logic [2:0] ADDR_SENSOR0 = 3'b010;
    localparam logic [2:0] ADDR_SENSOR1 = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_WRITE = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/sample_accumulator.sv
// rtl/sample_accumulator.sv - power-of-two batch accumulator with sample counter
module sample_accumulator #(
    parameter int DATA_W       = 16,
    parameter int SAMPLES_LOG2 = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           add_en,
    input  logic [DATA_W-1:0]              add_data,
    output logic [DATA_W+SAMPLES_LOG2-1:0] sum,
    output logic                           batch_done
);

    localparam int ACC_W = DATA_W + SAMPLES_LOG2;
    localparam int CNT_W = SAMPLES_LOG2 + 1;
    localparam int N     = 1 << SAMPLES_LOG2;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;

    // sum includes the sample being offered now, so the owner can capture the
    // full batch total on the same edge that accepts the last sample
    always_comb begin
        sum        = acc + ACC_W'(add_data);
        batch_done = add_en && (count == CNT_W'(N - 1));
    end

    // running total and sample count; both restart after a full batch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            count <= '0;
        end else if (clear || batch_done) begin
            acc   <= '0;
            count <= '0;
        end else if (add_en) begin
            acc   <= sum;
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/temp_sample_writer.sv
// rtl/temp_sample_writer.sv - averages sample batches and writes them to the sensor register
module temp_sample_writer
    import temp_sensor_pkg::*;
#(
    parameter int         DATA_W       = DATA_W_DEFAULT,
    parameter int         SAMPLES_LOG2 = 2,
    parameter logic [2:0] SENSOR_ADDR  = ADDR_SENSOR0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              sample_ready,
    output logic              write,
    output logic [2:0]        address,
    output logic [DATA_W-1:0] wr_data,
    output logic [7:0]        wr_count
);

    localparam int ACC_W = DATA_W + SAMPLES_LOG2;

    fsm_state_t       state;
    fsm_state_t       state_next;
    logic             accept;
    logic             acc_clear;
    logic             batch_done;
    logic [ACC_W-1:0] batch_sum;

    sample_accumulator #(
        .DATA_W       (DATA_W),
        .SAMPLES_LOG2 (SAMPLES_LOG2)
    ) u_acc (
        .clk        (clk),
        .reset      (reset),
        .clear      (acc_clear),
        .add_en     (accept),
        .add_data   (sample_data),
        .sum        (batch_sum),
        .batch_done (batch_done)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state and handshake/strobe outputs; ready is gated by enable so
    // no sample is handshaken in the cycle that abandons the batch
    always_comb begin
        state_next   = state;
        sample_ready = 1'b0;
        write        = 1'b0;
        address      = ADDR_IDLE;
        acc_clear    = 1'b1;
        case (state)
            ST_IDLE: begin
                if (enable) state_next = ST_ACCUM;
            end
            ST_ACCUM: begin
                sample_ready = enable;
                acc_clear    = !enable;
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (sample_valid && batch_done) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                write      = 1'b1;
                address    = SENSOR_ADDR;
                state_next = enable ? ST_ACCUM : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        accept = sample_ready && sample_valid;
    end

    // average and write counter are captured on the edge that enters WRITE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_data  <= '0;
            wr_count <= '0;
        end else if (accept && batch_done) begin
            wr_data  <= DATA_W'(batch_sum >> SAMPLES_LOG2);
            wr_count <= wr_count + 8'd1;
        end
    end

endmodule
